memstore_rmw: RTL

//  Store-side counterpart of the load formatter in the data-memory path.

---
 rtl/memstore_rmw.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/memstore_rmw.sv
// Store formatter for a doubleword memory without byte enables: full stores write
// directly, sub-doubleword stores read-merge-write, and STXR checks the exclusive monitor.
module memstore_rmw #(
  parameter int ADDR_W        = 64,
  parameter int RES_GRAN_LOG2 = 3,
  parameter logic [10:0] OPC_D_STUR  = 11'b11111000000,
  parameter logic [10:0] OPC_D_STURW = 11'b10111000000,
  parameter logic [10:0] OPC_D_STURH = 11'b01111000000,
  parameter logic [10:0] OPC_D_STURB = 11'b00111000000,
  parameter logic [10:0] OPC_D_STXR  = 11'b11001000000
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iStart,
  input  logic [10:0]       iOpcode,
  input  logic [ADDR_W-1:0] iAddr,
  input  logic [63:0]       iData,
  input  logic              iLdxrValid,
  input  logic [ADDR_W-1:0] iLdxrAddr,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr,
  output logic              oStatusWe,
  output logic [63:0]       oStatus,
  output logic [ADDR_W-1:0] oMemAddr,
  output logic              oMemRd,
  input  logic [63:0]       iMemRdata,
  input  logic              iMemRvalid,
  output logic              oMemWr,
  output logic [63:0]       oMemWdata,
  input  logic              iMemWack,
  output logic [1:0]        oState
);
  localparam int GRAN_W = ADDR_W - RES_GRAN_LOG2;

  // Memory handshake: oMemRd/oMemWr stay high until iMemRvalid/iMemWack is seen
  // on a rising edge; an ack in the same cycle as the request completes it.
  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;
  state_t state, state_next;

  logic [10:0]       op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       data_q, wdata_q;
  logic              err_q, stxr_q, fail_q;
  logic              res_valid;
  logic [GRAN_W-1:0] res_gran;

  logic        known, misal, sub, is_stxr, res_match, wr_clear;
  logic [63:0] lane_mask, mask, merged;
  logic [5:0]  shift;

  always_comb begin
    known   = 1'b1;
    misal   = 1'b0;
    sub     = 1'b0;
    is_stxr = 1'b0;
    case (iOpcode)
      OPC_D_STUR:  misal = (iAddr[2:0] != 3'b0);
      OPC_D_STXR:  begin misal = (iAddr[2:0] != 3'b0); is_stxr = 1'b1; end
      OPC_D_STURW: begin misal = (iAddr[1:0] != 2'b0); sub = 1'b1; end
      OPC_D_STURH: begin misal = iAddr[0]; sub = 1'b1; end
      OPC_D_STURB: sub = 1'b1;
      default:     known = 1'b0;
    endcase
    res_match = res_valid && (res_gran == iAddr[ADDR_W-1:RES_GRAN_LOG2]);
  end

  always_comb begin
    lane_mask = '1;
    case (op_q)
      OPC_D_STURB: lane_mask = 64'h0000_0000_0000_00FF;
      OPC_D_STURH: lane_mask = 64'h0000_0000_0000_FFFF;
      OPC_D_STURW: lane_mask = 64'h0000_0000_FFFF_FFFF;
      default:     lane_mask = '1;
    endcase
    shift  = {addr_q[2:0], 3'b000};
    mask   = lane_mask << shift;
    merged = (iMemRdata & ~mask) | ((data_q << shift) & mask);
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (iStart) begin
        if (!known || misal)          state_next = S_DONE;
        else if (is_stxr && !res_match) state_next = S_DONE;
        else if (sub)                 state_next = S_RD;
        else                          state_next = S_WR;
      end
      S_RD:    if (iMemRvalid) state_next = S_WR;
      S_WR:    if (iMemWack)   state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  assign wr_clear = (state == S_WR) && iMemWack && res_valid &&
                    (res_gran == addr_q[ADDR_W-1:RES_GRAN_LOG2]);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= S_IDLE;
      op_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
      stxr_q    <= 1'b0;
      fail_q    <= 1'b0;
      res_valid <= 1'b0;
      res_gran  <= '0;
    end else begin
      state <= state_next;
      if (state == S_IDLE && iStart) begin
        op_q    <= iOpcode;
        addr_q  <= iAddr;
        data_q  <= iData;
        wdata_q <= iData;
        err_q   <= !known || misal;
        stxr_q  <= is_stxr;
        fail_q  <= is_stxr && !res_match;
      end
      if (state == S_RD && iMemRvalid) wdata_q <= merged;
      // A new LDXR takes priority over a write that would clear the monitor.
      if (iLdxrValid) begin
        res_valid <= 1'b1;
        res_gran  <= iLdxrAddr[ADDR_W-1:RES_GRAN_LOG2];
      end else if (wr_clear) begin
        res_valid <= 1'b0;
      end
    end
  end

  assign oState    = state;
  assign oBusy     = (state != S_IDLE);
  assign oDone     = (state == S_DONE);
  assign oErr      = (state == S_DONE) && err_q;
  assign oStatusWe = (state == S_DONE) && stxr_q && !err_q;
  assign oStatus   = {63'b0, (state == S_DONE) && stxr_q && !err_q && fail_q};
  assign oMemAddr  = {addr_q[ADDR_W-1:3], 3'b000};
  assign oMemRd    = (state == S_RD);
  assign oMemWr    = (state == S_WR);
  assign oMemWdata = wdata_q;

endmodule
